cbfp_norm: RTL
==============

CBFP_NORM -- requirements
Module: cbfp_norm

Interface
REQ-001 SHALL have parameter BW_IN, default 23, input sample width (two's complement).
REQ-002 SHALL have parameter BW_OUT, default 11, normalized output width; BW_OUT < BW_IN.
REQ-003 SHALL have parameter BLOCK_SIZE, default 64, complex points sharing one exponent.
REQ-004 SHALL have parameter BATCH_SIZE, default 16, points per beat; BLOCK_SIZE multiple of BATCH_SIZE.
REQ-005 SHALL have parameter EXP_W, default 5, exponent width; 2**EXP_W > BW_IN-1.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rstn, input, 1, reset; synchronous, active-low.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input beat handshake.
REQ-009 SHALL have ports in_re and in_im, input, BATCH_SIZE x BW_IN signed, input beat.
REQ-010 SHALL have ports out_valid (input... output, 1) and out_ready (input, 1), output beat handshake.
REQ-011 SHALL have ports out_re and out_im, output, BATCH_SIZE x BW_OUT signed, normalized beat.
REQ-012 SHALL have port out_exp, output, EXP_W, block shift count, constant for all beats of a block.
REQ-013 SHALL have port out_last, output, 1, high on final beat of a block.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready; BEATS = BLOCK_SIZE/BATCH_SIZE beats form one block.
REQ-015 SHALL store blocks in two banks (ping-pong); each bank status is EMPTY -> FILL -> FULL -> DRAIN -> EMPTY.
REQ-016 SHALL drive in_ready high iff the current write bank is EMPTY or FILL.
REQ-017 SHALL compute per sample lsb(x) = count of bits below the MSB equal to the MSB, range 0..BW_IN-1 (0 and -1 give BW_IN-1).
REQ-018 SHALL keep a running minimum over re and im of every accepted beat, updated incrementally per beat, not as a BLOCK_SIZE-wide chain.
REQ-019 SHALL latch exp = block minimum into the bank on the last accepted beat; the accumulator restarts at BW_IN-1 for the next block in the same cycle.
REQ-020 SHALL output y = bits [BW_IN-1 : BW_IN-BW_OUT] of (x <<< exp); no overflow is possible by construction.
REQ-021 SHALL assert out_valid the cycle after the last beat of a block is accepted (latency 1) when the read bank is idle.
REQ-022 SHALL hold out_re/out_im/out_exp/out_last stable while out_valid && !out_ready.
REQ-023 SHALL advance one beat per out_valid && out_ready; on the beat with out_last the bank goes EMPTY and the read side switches banks.
REQ-024 SHALL allow, in the same cycle, the last write of one bank and the last read of the other; in_ready stays high, with no bubble on either side.
REQ-025 SHALL sustain one input and one output beat per cycle indefinitely when out_ready is held high.
REQ-026 SHALL ignore in_re/in_im when in_valid is low; out_* data is don't-care when out_valid is low.

Reset
REQ-027 SHALL, on rising clk with rstn low, set both banks EMPTY, write/read bank select 0, beat counters 0, min accumulator BW_IN-1, out_valid 0, out_last 0, out_exp 0, out_re/out_im 0.
REQ-028 SHALL discard any partial or undrained block on reset mid-operation; in_ready is 1 in the first cycle after reset release.

Configuration
REQ-029 SHALL, with CBFP_NORM_ROUND_EN defined, round half-up at bit BW_IN-BW_OUT-1 of the shifted value and saturate to the signed BW_OUT range.
REQ-030 SHALL, without CBFP_NORM_ROUND_EN, truncate (arithmetic floor) as in REQ-020; latency is unchanged in both builds.

Structure
REQ-031 SHALL place bank status enum, default widths, and the BEATS derivation helper in shared package cbfp_pkg.
REQ-032 SHALL implement the per-sample count of REQ-017 in sub-module lead_sign_cnt (parameter WIDTH), instantiated 2*BATCH_SIZE times.

Verification
REQ-033 SHALL cover: one block, one sample re=0x000400, rest 0 -> out_exp=11, that out_re=512, others 0, out_last on beat 4.
REQ-034 SHALL cover: all-zero block -> out_exp=22, all outputs 0.
REQ-035 SHALL cover: one sample re=-2^22 -> out_exp=0, that out_re=-1024; with CBFP_NORM_ROUND_EN, sample 0x0007FF alone -> exp=11, out=1023 (saturated; 1023 truncated).
REQ-036 SHALL cover: 3 back-to-back blocks with out_ready=1 -> in_ready never low, 12 contiguous output beats, first at latency 1.
REQ-037 SHALL cover: out_ready=0 while 2 blocks are sent -> in_ready low after beat 8; outputs stable; out_ready=1 -> drains in order, in_ready returns high.
REQ-038 SHALL cover: rstn low after 2 beats of a block -> next cycle out_valid=0, in_ready=1; the next full block is processed with a fresh exponent.

Source files
------------

// File: rtl/cbfp_pkg.sv
// Shared types and defaults for the block-floating-point normalizer.
package cbfp_pkg;

  typedef enum logic [1:0] {BankEmpty, BankFill, BankFull, BankDrain} bank_st_e;

  localparam int unsigned DefBwIn      = 23;
  localparam int unsigned DefBwOut     = 11;
  localparam int unsigned DefBlockSize = 64;
  localparam int unsigned DefBatchSize = 16;
  localparam int unsigned DefExpW      = 5;

  function automatic int unsigned calc_beats(int unsigned block_size, int unsigned batch_size);
    return block_size / batch_size;
  endfunction

endpackage

// File: rtl/cbfp_norm_if.sv
// Input and output beat streams of cbfp_norm; slave is the DUT view, master the source/sink.
interface cbfp_norm_if #(
    parameter int unsigned BW_IN      = cbfp_pkg::DefBwIn,
    parameter int unsigned BW_OUT     = cbfp_pkg::DefBwOut,
    parameter int unsigned BATCH_SIZE = cbfp_pkg::DefBatchSize,
    parameter int unsigned EXP_W      = cbfp_pkg::DefExpW
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [BW_IN-1:0]  in_re [BATCH_SIZE];
    logic signed [BW_IN-1:0]  in_im [BATCH_SIZE];
    logic                     out_valid;
    logic                     out_ready;
    logic signed [BW_OUT-1:0] out_re [BATCH_SIZE];
    logic signed [BW_OUT-1:0] out_im [BATCH_SIZE];
    logic [EXP_W-1:0]         out_exp;
    logic                     out_last;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_exp, out_last
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_exp, out_last
    );
endinterface

// File: rtl/lead_sign_cnt.sv
// Counts the redundant sign bits directly below the MSB of a two's complement value.
module lead_sign_cnt #(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned CNT_W = 5
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [CNT_W-1:0] cnt_o
);
    always_comb begin
        logic run;
        run   = 1'b1;
        cnt_o = '0;
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            if (run && (x_i[i] == x_i[WIDTH-1])) cnt_o = cnt_o + CNT_W'(1);
            else run = 1'b0;
        end
    end
endmodule

// File: rtl/cbfp_norm.sv
// Ping-pong block-floating-point normalizer: one shared exponent per block of complex samples.
// Define CBFP_NORM_ROUND_EN to round half-up with saturation instead of truncating.
module cbfp_norm
    import cbfp_pkg::*;
#(
    parameter int unsigned BW_IN      = DefBwIn,
    parameter int unsigned BW_OUT     = DefBwOut,
    parameter int unsigned BLOCK_SIZE = DefBlockSize,
    parameter int unsigned BATCH_SIZE = DefBatchSize,
    parameter int unsigned EXP_W      = DefExpW
) (
    input logic       clk,
    input logic       rstn,
    cbfp_norm_if.slave bus
);
    localparam int unsigned BEATS  = calc_beats(BLOCK_SIZE, BATCH_SIZE);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [EXP_W-1:0]  EXP_INIT  = EXP_W'(BW_IN - 1);

    logic signed [BW_IN-1:0] mem_re [2][BEATS][BATCH_SIZE];
    logic signed [BW_IN-1:0] mem_im [2][BEATS][BATCH_SIZE];

    bank_st_e                 bank_st_q  [2];
    logic [EXP_W-1:0]         bank_exp_q [2];
    logic                     wr_sel_q, ld_sel_q, out_bank_q;
    logic [BEAT_W-1:0]        wr_cnt_q, ld_cnt_q;
    logic [EXP_W-1:0]         min_q, min_next;
    logic                     out_valid_q, out_last_q;
    logic [EXP_W-1:0]         out_exp_q;
    logic signed [BW_OUT-1:0] out_re_q [BATCH_SIZE];
    logic signed [BW_OUT-1:0] out_im_q [BATCH_SIZE];

    logic [EXP_W-1:0]        lsb_re [BATCH_SIZE];
    logic [EXP_W-1:0]        lsb_im [BATCH_SIZE];
    logic signed [BW_IN-1:0] ld_re  [BATCH_SIZE];
    logic signed [BW_IN-1:0] ld_im  [BATCH_SIZE];
    logic                    in_ready, in_fire, in_last, blk_byp, ld_byp, ld_avail, ld_en;
    logic                    release_bank;
    logic [EXP_W-1:0]        ld_exp;

    for (genvar g = 0; g < BATCH_SIZE; g++) begin : g_lsb
        lead_sign_cnt #(.WIDTH(BW_IN), .CNT_W(EXP_W)) u_re (.x_i(bus.in_re[g]), .cnt_o(lsb_re[g]));
        lead_sign_cnt #(.WIDTH(BW_IN), .CNT_W(EXP_W)) u_im (.x_i(bus.in_im[g]), .cnt_o(lsb_im[g]));
    end

    function automatic logic signed [BW_OUT-1:0] norm(logic signed [BW_IN-1:0] x,
                                                      logic [EXP_W-1:0] e);
        logic signed [BW_IN-1:0] s;
`ifdef CBFP_NORM_ROUND_EN
        logic signed [BW_OUT:0] r;
        s = x <<< e;
        r = {s[BW_IN-1], s[BW_IN-1 -: BW_OUT]} + {{BW_OUT{1'b0}}, s[BW_IN-BW_OUT-1]};
        // Only max positive plus a round bit can overflow.
        if (r[BW_OUT] != r[BW_OUT-1]) return {1'b0, {(BW_OUT-1){1'b1}}};
        return r[BW_OUT-1:0];
`else
        s = x <<< e;
        return s[BW_IN-1 -: BW_OUT];
`endif
    endfunction

    always_comb begin
        min_next = min_q;
        for (int i = 0; i < BATCH_SIZE; i++) begin
            if (lsb_re[i] < min_next) min_next = lsb_re[i];
            if (lsb_im[i] < min_next) min_next = lsb_im[i];
        end
    end

    assign in_ready     = bank_st_q[wr_sel_q] inside {BankEmpty, BankFill};
    assign in_fire      = bus.in_valid && in_ready;
    assign in_last      = in_fire && (wr_cnt_q == BEAT_LAST);
    // The block completing this cycle can be read straight away with its fresh exponent.
    assign blk_byp      = in_last && (wr_sel_q == ld_sel_q);
    assign ld_byp       = in_fire && (wr_sel_q == ld_sel_q) && (wr_cnt_q == ld_cnt_q);
    assign ld_avail     = (bank_st_q[ld_sel_q] inside {BankFull, BankDrain}) || blk_byp;
    assign ld_en        = ld_avail && (!out_valid_q || bus.out_ready);
    assign ld_exp       = blk_byp ? min_next : bank_exp_q[ld_sel_q];
    assign release_bank = out_valid_q && bus.out_ready && out_last_q;

    always_comb begin
        for (int i = 0; i < BATCH_SIZE; i++) begin
            ld_re[i] = ld_byp ? bus.in_re[i] : mem_re[ld_sel_q][ld_cnt_q][i];
            ld_im[i] = ld_byp ? bus.in_im[i] : mem_im[ld_sel_q][ld_cnt_q][i];
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < BATCH_SIZE; i++) begin
                mem_re[wr_sel_q][wr_cnt_q][i] <= bus.in_re[i];
                mem_im[wr_sel_q][wr_cnt_q][i] <= bus.in_im[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b]  <= BankEmpty;
                bank_exp_q[b] <= '0;
            end
            wr_sel_q    <= 1'b0;
            ld_sel_q    <= 1'b0;
            out_bank_q  <= 1'b0;
            wr_cnt_q    <= '0;
            ld_cnt_q    <= '0;
            min_q       <= EXP_INIT;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_exp_q   <= '0;
            for (int i = 0; i < BATCH_SIZE; i++) begin
                out_re_q[i] <= '0;
                out_im_q[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                if (in_last) begin
                    bank_st_q[wr_sel_q]  <= BankFull;
                    bank_exp_q[wr_sel_q] <= min_next;
                    wr_sel_q             <= ~wr_sel_q;
                    wr_cnt_q             <= '0;
                    min_q                <= EXP_INIT;
                end else begin
                    bank_st_q[wr_sel_q] <= BankFill;
                    wr_cnt_q            <= wr_cnt_q + BEAT_W'(1);
                    min_q               <= min_next;
                end
            end
            if (ld_en) begin
                bank_st_q[ld_sel_q] <= BankDrain;
                out_valid_q         <= 1'b1;
                out_last_q          <= (ld_cnt_q == BEAT_LAST);
                out_exp_q           <= ld_exp;
                out_bank_q          <= ld_sel_q;
                for (int i = 0; i < BATCH_SIZE; i++) begin
                    out_re_q[i] <= norm(ld_re[i], ld_exp);
                    out_im_q[i] <= norm(ld_im[i], ld_exp);
                end
                if (ld_cnt_q == BEAT_LAST) begin
                    ld_cnt_q <= '0;
                    ld_sel_q <= ~ld_sel_q;
                end else begin
                    ld_cnt_q <= ld_cnt_q + BEAT_W'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (release_bank) bank_st_q[out_bank_q] <= BankEmpty;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
endmodule
